// File: rtl/mux_n1_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_n1_arb_pkg : shared mode encodings and width helper   (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

package mux_n1_arb_pkg;

    localparam int MODE_RR   = 0;
    localparam int MODE_PRIO = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_n1_arb_arb.sv
// -----------------------------------------------------------------------------
// rr_burst_arb : round-robin-with-burst / fixed-priority grant selector (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module rr_burst_arb
    import mux_n1_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int BURST  = 2,
    parameter int MODE   = MODE_RR,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] valid_i,
    input  logic              advance_i,
    output logic [CH_W-1:0]   grant_o,
    output logic              grant_vld_o
);

    localparam logic [3:0] BURST_LIM = 4'(BURST - 1);

    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [3:0]      burst_q, burst_d;
    logic            active_q, active_d;

    logic [CH_W-1:0] srch_idx, prio_idx, c_idx;
    logic            srch_vld, prio_vld, hold;

    always_comb begin
        int c;
        c        = 0;
        c_idx    = '0;
        srch_idx = '0;
        srch_vld = 1'b0;
        prio_idx = '0;
        prio_vld = 1'b0;
        // Descending scan so the nearest channel after the pointer wins last.
        for (int off = NUM_CH; off >= 1; off--) begin
            c = int'(ptr_q) + off;
            if (c >= NUM_CH) c = c - NUM_CH;
            c_idx = c[CH_W-1:0];
            if (valid_i[c_idx]) begin
                srch_vld = 1'b1;
                srch_idx = c_idx;
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (valid_i[i]) begin
                prio_vld = 1'b1;
                prio_idx = CH_W'(i);
            end
        end
    end

    // active_q stays low until the first grant so the post-reset search starts at ch0.
    assign hold = active_q && valid_i[ptr_q] && (burst_q < BURST_LIM);

    always_comb begin
        grant_o     = ptr_q;
        grant_vld_o = 1'b0;
        ptr_d       = ptr_q;
        burst_d     = burst_q;
        active_d    = active_q | advance_i;
        if (MODE == MODE_PRIO) begin
            grant_o     = prio_idx;
            grant_vld_o = prio_vld;
            burst_d     = '0;
        end else if (hold) begin
            grant_o     = ptr_q;
            grant_vld_o = 1'b1;
            if (advance_i) burst_d = burst_q + 4'd1;
        end else begin
            grant_o     = srch_idx;
            grant_vld_o = srch_vld;
            if (advance_i) burst_d = '0;
        end
        if (advance_i) ptr_d = grant_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= CH_W'(NUM_CH - 1);
            burst_q  <= '0;
            active_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            burst_q  <= burst_d;
            active_q <= active_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_n1_arb.sv
// -----------------------------------------------------------------------------
// mux_n1_arb : N:1 arbitrated FIFO-drain mux with registered output (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module mux_n1_arb
    import mux_n1_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 10,
    parameter int OUT_W  = 8,
    parameter int BURST  = 2,
    parameter int MODE   = MODE_RR,
    localparam int CH_W  = clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH*IN_W-1:0] in_data_i,
    input  logic [NUM_CH-1:0]      in_valid_i,
    input  logic                   out_ready_i,
    output logic [NUM_CH-1:0]      pop_o,
    output logic [OUT_W-1:0]       out_o,
    output logic                   valid_out_o,
    output logic [CH_W-1:0]        out_ch_o
);

    logic [CH_W-1:0]  grant;
    logic             grant_vld;
    logic             load_en;
    logic [OUT_W-1:0] word_sel;
    logic             unused_in_bits;

    logic [OUT_W-1:0] out_q;
    logic [CH_W-1:0]  out_ch_q;
    logic             valid_q;

    rr_burst_arb #(
        .NUM_CH (NUM_CH),
        .BURST  (BURST),
        .MODE   (MODE),
        .CH_W   (CH_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (in_valid_i),
        .advance_i   (load_en),
        .grant_o     (grant),
        .grant_vld_o (grant_vld)
    );

    // Gating with rst_n keeps pop silent for the whole reset interval.
    assign load_en = rst_n & (~valid_q | out_ready_i) & grant_vld;

    always_comb begin
        pop_o = '0;
        if (load_en) pop_o[grant] = 1'b1;
    end

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == CH_W'(i)) word_sel = in_data_i[i*IN_W +: OUT_W];
        end
    end

    assign unused_in_bits = ^in_data_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            out_ch_q <= '0;
            valid_q  <= 1'b0;
        end else if (load_en) begin
            out_q    <= word_sel;
            out_ch_q <= grant;
            valid_q  <= 1'b1;
        end else if (out_ready_i) begin
            valid_q  <= 1'b0;
        end
    end

    assign out_o       = out_q;
    assign out_ch_o    = out_ch_q;
    assign valid_out_o = valid_q;

endmodule

`default_nettype wire
